// File: rtl/trd_sched_if.sv
// Thread-scheduler bus: everything between the core and trd_sched except clk/rst.
//   master : core side, drives enables, stall, miss/fill and exception events,
//            observes the selected thread and scheduler status.
//   slave  : trd_sched side.
interface trd_sched_if #(
  parameter int NUM_TRD = 8,
  parameter int TRD_W   = $clog2(NUM_TRD)
);
  logic [NUM_TRD-1:0] trd_en;
  logic               stall;
  logic               i_miss;
  logic [TRD_W-1:0]   i_miss_trd;
  logic               i_fill;
  logic [TRD_W-1:0]   i_fill_trd;
  logic               d_miss;
  logic [TRD_W-1:0]   d_miss_trd;
  logic               d_fill;
  logic [TRD_W-1:0]   d_fill_trd;
  logic               exp_enter;
  logic [TRD_W-1:0]   exp_trd;
  logic               exp_return;
  logic [TRD_W-1:0]   cur_trd;
  logic               trd_vld;
  logic [NUM_TRD-1:0] rdy_mask;
  logic               exp_mode;
  logic [TRD_W-1:0]   exp_owner;

  modport master (
    output trd_en, stall, i_miss, i_miss_trd, i_fill, i_fill_trd,
           d_miss, d_miss_trd, d_fill, d_fill_trd, exp_enter, exp_trd, exp_return,
    input  cur_trd, trd_vld, rdy_mask, exp_mode, exp_owner
  );

  modport slave (
    input  trd_en, stall, i_miss, i_miss_trd, i_fill, i_fill_trd,
           d_miss, d_miss_trd, d_fill, d_fill_trd, exp_enter, exp_trd, exp_return,
    output cur_trd, trd_vld, rdy_mask, exp_mode, exp_owner
  );
endinterface

// File: rtl/trd_sched.sv
// Barrel-thread scheduler for the 8-thread core.
//   trd_fsm   : per-thread IDLE/READY/WAIT_I/WAIT_D tracker, one instance per thread.
//   trd_sched : round-robin pick among READY threads (restricted to the exception
//               owner while exception mode is active), registered into cur_trd.
// Ports (trd_sched):
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : trd_sched_if.slave (enables, stall, miss/fill, exception events in;
//          cur_trd, trd_vld, rdy_mask, exp_mode, exp_owner out)

// Per-thread state tracker. Inputs are already decoded for this thread.
//   en     : thread enable (0 forces IDLE and drops any pending wait)
//   d_miss/i_miss/d_fill/i_fill : events addressed to this thread
//   rdy    : thread is READY (decoded straight from the state flop)
module trd_fsm (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d_miss,
  input  logic i_miss,
  input  logic d_fill,
  input  logic i_fill,
  output logic rdy
);
  typedef enum logic [1:0] {IDLE, READY, WAIT_I, WAIT_D} state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Misses beat fills, so a same-cycle miss+fill leaves the thread waiting.
  always_comb begin
    state_nxt = state;
    if (!en)         state_nxt = IDLE;
    else if (d_miss) state_nxt = WAIT_D;
    else if (i_miss) state_nxt = WAIT_I;
    else begin
      case (state)
        IDLE:    state_nxt = READY;
        WAIT_I:  if (i_fill) state_nxt = READY;
        WAIT_D:  if (d_fill) state_nxt = READY;
        default: state_nxt = state;
      endcase
    end
  end

  assign rdy = (state == READY);
endmodule

module trd_sched #(
  parameter int NUM_TRD = 8,
  parameter int TRD_W   = $clog2(NUM_TRD)
) (
  input logic       clk,
  input logic       rst,
  trd_sched_if.slave bus
);
  logic [NUM_TRD-1:0] rdy;
  logic [NUM_TRD-1:0] elig;
  logic [NUM_TRD-1:0] owner_oh;
  logic [TRD_W-1:0]   ptr_q;
  logic [TRD_W-1:0]   cur_q;
  logic               vld_q;
  logic               exp_mode_q;
  logic [TRD_W-1:0]   exp_owner_q;
  logic [TRD_W-1:0]   pick;
  logic [TRD_W-1:0]   idx;
  logic               found;

  generate
    for (genvar g = 0; g < NUM_TRD; g++) begin : g_trd
      localparam logic [TRD_W-1:0] ID = TRD_W'(g);
      trd_fsm u_fsm (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.trd_en[g]),
        .d_miss (bus.d_miss && (bus.d_miss_trd == ID)),
        .i_miss (bus.i_miss && (bus.i_miss_trd == ID)),
        .d_fill (bus.d_fill && (bus.d_fill_trd == ID)),
        .i_fill (bus.i_fill && (bus.i_fill_trd == ID)),
        .rdy    (rdy[g])
      );
    end
  endgenerate

  // Scan ptr+1 .. ptr+NUM_TRD; the last step wraps back onto ptr itself so a
  // lone ready thread keeps issuing. The TRD_W-bit add gives the mod wrap.
  always_comb begin
    owner_oh = '0;
    owner_oh[exp_owner_q] = 1'b1;
    elig  = exp_mode_q ? (rdy & owner_oh) : rdy;
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_TRD; i++) begin
      idx = ptr_q + TRD_W'(i);
      if (!found && elig[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= TRD_W'(NUM_TRD - 1);
      cur_q       <= '0;
      vld_q       <= 1'b0;
      exp_mode_q  <= 1'b0;
      exp_owner_q <= '0;
    end else begin
      // Stall freezes the issue slot; thread state above keeps tracking events.
      if (!bus.stall) begin
        if (found) begin
          cur_q <= pick;
          ptr_q <= pick;
          vld_q <= 1'b1;
        end else begin
          vld_q <= 1'b0;
        end
      end
      // Return has priority while in exception mode; enter only when not in it.
      if (exp_mode_q) begin
        if (bus.exp_return) exp_mode_q <= 1'b0;
      end else if (bus.exp_enter) begin
        exp_mode_q  <= 1'b1;
        exp_owner_q <= bus.exp_trd;
      end
    end
  end

  assign bus.cur_trd   = cur_q;
  assign bus.trd_vld   = vld_q;
  assign bus.rdy_mask  = rdy;
  assign bus.exp_mode  = exp_mode_q;
  assign bus.exp_owner = exp_owner_q;
endmodule

// File: tb/tb_trd_sched.sv
module tb_trd_sched;
  localparam int EV_N  = 0;  // no event
  localparam int EV_IM = 1;  // i_miss
  localparam int EV_IF = 2;  // i_fill
  localparam int EV_DM = 3;  // d_miss
  localparam int EV_DF = 4;  // d_fill
  localparam int EV_EE = 5;  // exp_enter
  localparam int EV_ER = 6;  // exp_return
  localparam int EV_EB = 7;  // exp_enter + exp_return
  localparam int EV_DB = 8;  // d_miss + d_fill

  typedef struct {
    logic       rst;
    logic [7:0] en;
    logic       stall;
    int         ev;
    logic [2:0] evt;
    logic [2:0] cur;
    logic       vld;
    logic [7:0] rdy;
    logic       em;
    logic [2:0] eo;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  trd_sched_if #(.NUM_TRD(8), .TRD_W(3)) bus ();

  trd_sched #(.NUM_TRD(8), .TRD_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(logic r, logic [7:0] en, logic st, int ev, logic [2:0] evt,
                              logic [2:0] cur, logic vld, logic [7:0] rdy, logic em, logic [2:0] eo);
    vec_t v;
    v.rst = r; v.en = en; v.stall = st; v.ev = ev; v.evt = evt;
    v.cur = cur; v.vld = vld; v.rdy = rdy; v.em = em; v.eo = eo;
    vecs.push_back(v);
  endfunction

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic drive(logic r, logic [7:0] en, logic st, int ev, logic [2:0] evt);
    rst            = r;
    bus.trd_en     = en;
    bus.stall      = st;
    bus.i_miss     = (ev == EV_IM);
    bus.i_fill     = (ev == EV_IF);
    bus.d_miss     = (ev == EV_DM) || (ev == EV_DB);
    bus.d_fill     = (ev == EV_DF) || (ev == EV_DB);
    bus.exp_enter  = (ev == EV_EE) || (ev == EV_EB);
    bus.exp_return = (ev == EV_ER) || (ev == EV_EB);
    bus.i_miss_trd = evt; bus.i_fill_trd = evt;
    bus.d_miss_trd = evt; bus.d_fill_trd = evt;
    bus.exp_trd    = evt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    drive(1'b1, 8'h00, 1'b0, EV_N, 3'd0);

    // reset, then all threads enabled: fill-in cycle, then 0..7,0
    add(1, 8'h00, 0, EV_N, 0, 0, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 0, EV_N, 0, 0, 0, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N, 0, 0, 1, 8'hFF, 0, 0);
    for (int k = 1; k < 8; k++) add(0, 8'hFF, 0, EV_N, 0, 3'(k), 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N, 0, 0, 1, 8'hFF, 0, 0);

    // only threads 0 and 2
    add(1, 8'h05, 0, EV_N, 0, 0, 0, 8'h00, 0, 0);
    add(0, 8'h05, 0, EV_N, 0, 0, 0, 8'h05, 0, 0);
    add(0, 8'h05, 0, EV_N, 0, 0, 1, 8'h05, 0, 0);
    add(0, 8'h05, 0, EV_N, 0, 2, 1, 8'h05, 0, 0);
    add(0, 8'h05, 0, EV_N, 0, 0, 1, 8'h05, 0, 0);
    add(0, 8'h05, 0, EV_N, 0, 2, 1, 8'h05, 0, 0);

    // d_miss on 3: skipped, i_fill ignored, d_fill releases
    add(1, 8'hFF, 0, EV_N,  0, 0, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 0, 0, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 0, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_DM, 3, 1, 1, 8'hF7, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 2, 1, 8'hF7, 0, 0);
    add(0, 8'hFF, 0, EV_IF, 3, 4, 1, 8'hF7, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 5, 1, 8'hF7, 0, 0);
    add(0, 8'hFF, 0, EV_DF, 3, 6, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 7, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 0, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 1, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 2, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 3, 1, 8'hFF, 0, 0);

    // lone thread 5 with an I-miss
    add(1, 8'h20, 0, EV_N,  0, 0, 0, 8'h00, 0, 0);
    add(0, 8'h20, 0, EV_N,  0, 0, 0, 8'h20, 0, 0);
    add(0, 8'h20, 0, EV_N,  0, 5, 1, 8'h20, 0, 0);
    add(0, 8'h20, 0, EV_N,  0, 5, 1, 8'h20, 0, 0);
    add(0, 8'h20, 0, EV_IM, 5, 5, 1, 8'h00, 0, 0);
    add(0, 8'h20, 0, EV_N,  0, 5, 0, 8'h00, 0, 0);
    add(0, 8'h20, 0, EV_N,  0, 5, 0, 8'h00, 0, 0);
    add(0, 8'h20, 0, EV_IF, 5, 5, 0, 8'h20, 0, 0);
    add(0, 8'h20, 0, EV_N,  0, 5, 1, 8'h20, 0, 0);

    // exception mode
    add(1, 8'hFF, 0, EV_N,  0, 0, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 0, 0, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 0, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 1, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_EE, 6, 2, 1, 8'hFF, 1, 6);
    add(0, 8'hFF, 0, EV_N,  0, 6, 1, 8'hFF, 1, 6);
    add(0, 8'hFF, 0, EV_EE, 2, 6, 1, 8'hFF, 1, 6);
    add(0, 8'hFF, 0, EV_N,  0, 6, 1, 8'hFF, 1, 6);
    add(0, 8'hFF, 0, EV_ER, 0, 6, 1, 8'hFF, 0, 6);
    add(0, 8'hFF, 0, EV_N,  0, 7, 1, 8'hFF, 0, 6);
    add(0, 8'hFF, 0, EV_N,  0, 0, 1, 8'hFF, 0, 6);
    add(0, 8'hFF, 0, EV_EB, 3, 1, 1, 8'hFF, 1, 3);
    add(0, 8'hFF, 0, EV_EB, 5, 3, 1, 8'hFF, 0, 3);
    add(0, 8'hFF, 0, EV_N,  0, 4, 1, 8'hFF, 0, 3);
    add(0, 8'hFF, 0, EV_EE, 4, 5, 1, 8'hFF, 1, 4);
    add(0, 8'hFF, 0, EV_IM, 4, 4, 1, 8'hEF, 1, 4);
    add(0, 8'hFF, 0, EV_N,  0, 4, 0, 8'hEF, 1, 4);
    add(0, 8'hFF, 0, EV_IF, 4, 4, 0, 8'hFF, 1, 4);
    add(0, 8'hFF, 0, EV_N,  0, 4, 1, 8'hFF, 1, 4);
    add(0, 8'hFF, 0, EV_ER, 0, 4, 1, 8'hFF, 0, 4);
    add(0, 8'hFF, 0, EV_N,  0, 5, 1, 8'hFF, 0, 4);

    // stall for 3 cycles; same-cycle d_miss+d_fill on 4 during the stall
    add(1, 8'hFF, 0, EV_N,  0, 0, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 0, 0, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 0, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 1, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 2, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 1, EV_N,  0, 2, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 1, EV_DB, 4, 2, 1, 8'hEF, 0, 0);
    add(0, 8'hFF, 1, EV_N,  0, 2, 1, 8'hEF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 3, 1, 8'hEF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 5, 1, 8'hEF, 0, 0);
    add(0, 8'hFF, 0, EV_IF, 4, 6, 1, 8'hEF, 0, 0);
    add(0, 8'hFF, 0, EV_DF, 4, 7, 1, 8'hFF, 0, 0);
    add(0, 8'hFF, 0, EV_N,  0, 0, 1, 8'hFF, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].stall, vecs[i].ev, vecs[i].evt);
      checks++;
      if (bus.cur_trd !== vecs[i].cur || bus.trd_vld !== vecs[i].vld ||
          bus.rdy_mask !== vecs[i].rdy || bus.exp_mode !== vecs[i].em ||
          bus.exp_owner !== vecs[i].eo) begin
        errors++;
        $display("FAIL vec%0d: got cur=%0d vld=%0b rdy=%h em=%0b eo=%0d, expected cur=%0d vld=%0b rdy=%h em=%0b eo=%0d",
                 i, bus.cur_trd, bus.trd_vld, bus.rdy_mask, bus.exp_mode, bus.exp_owner,
                 vecs[i].cur, vecs[i].vld, vecs[i].rdy, vecs[i].em, vecs[i].eo);
      end
    end

    // disabling a waiting thread drops its wait; re-enable goes straight to READY
    drive(1'b0, 8'hFF, 1'b0, EV_DM, 3'd3);
    chk("wait_d3_rdy", bus.rdy_mask, 8'hF7);
    drive(1'b0, 8'hF7, 1'b0, EV_N, 3'd0);
    chk("dis3_rdy", bus.rdy_mask, 8'hF7);
    drive(1'b0, 8'hFF, 1'b0, EV_N, 3'd0);
    chk("reen3_rdy", bus.rdy_mask, 8'hFF);

    // reset mid-operation with exception mode and a pending I-wait
    drive(1'b0, 8'hFF, 1'b0, EV_EE, 3'd1);
    chk("pre_rst_em", {7'd0, bus.exp_mode}, 8'h01);
    chk("pre_rst_eo", {5'd0, bus.exp_owner}, 8'h01);
    drive(1'b0, 8'hFF, 1'b0, EV_IM, 3'd2);
    chk("pre_rst_rdy", bus.rdy_mask, 8'hFB);
    drive(1'b1, 8'hFF, 1'b0, EV_N, 3'd0);
    chk("rst_cur", {5'd0, bus.cur_trd}, 8'h00);
    chk("rst_vld", {7'd0, bus.trd_vld}, 8'h00);
    chk("rst_rdy", bus.rdy_mask, 8'h00);
    chk("rst_em", {7'd0, bus.exp_mode}, 8'h00);
    chk("rst_eo", {5'd0, bus.exp_owner}, 8'h00);
    drive(1'b0, 8'hFF, 1'b0, EV_N, 3'd0);
    chk("post_rst_rdy", bus.rdy_mask, 8'hFF);
    chk("post_rst_vld", {7'd0, bus.trd_vld}, 8'h00);
    drive(1'b0, 8'hFF, 1'b0, EV_N, 3'd0);
    chk("post_rst_cur", {5'd0, bus.cur_trd}, 8'h00);
    chk("post_rst_vld1", {7'd0, bus.trd_vld}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
